// File: rtl/fir_dac_spi_tx.sv
// Rounds/saturates a signed FIR sample to DAC width, converts to offset binary and
// shifts it out as a 16-bit SPI frame. Define DAC_PENDING_EN for a one-entry pending slot.
module fir_dac_spi_tx #(
    parameter int IN_W     = 29,
    parameter int DAC_W    = 12,
    parameter int SHIFT    = 17,
    parameter int SCLK_DIV = 4,
    parameter int GAP_CYC  = 8
) (
    input  logic            CLOCK,
    input  logic            RESET,
    input  logic            sample_valid,
    input  logic [IN_W-1:0] sample_in,
    output logic            busy,
    output logic            sat_pulse,
    output logic            dropped,
    output logic            dac_sclk,
    output logic            dac_sync_n,
    output logic            dac_din
);
    localparam int QW = IN_W + 1 - SHIFT;
    localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic signed [QW-1:0]   Q_MAX = QW'((1 << (DAC_W - 1)) - 1);
    localparam logic signed [QW-1:0]   Q_MIN = QW'(-(1 << (DAC_W - 1)));
    localparam logic signed [IN_W:0]   RND   = (IN_W + 1)'(64'd1 << (SHIFT - 1));

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_GAP} state_e;

    state_e            state_q, state_d;
    logic [DW-1:0]     div_q, div_d;
    logic [4:0]        half_q, half_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [IN_W-1:0]   smp_q, smp_d;
    logic [15:0]       sreg_q, sreg_d;
    logic              sclk_q, sclk_d, sync_q, sync_d, din_q, din_d;

    logic signed [IN_W:0]   rnd;
    logic signed [QW-1:0]   q;
    logic                   sat_hi, sat_lo;
    logic [DAC_W-1:0]       code;
    logic                   div_end, shift_end, gap_end;
    logic                   pend_take, gap_take;
    logic [IN_W-1:0]        pend_smp_q;

    // Round half up in one extra bit so the +2^(SHIFT-1) never wraps.
    assign rnd    = $signed({smp_q[IN_W-1], smp_q}) + RND;
    assign q      = QW'(rnd >>> SHIFT);
    assign sat_hi = q > Q_MAX;
    assign sat_lo = q < Q_MIN;

    always_comb begin
        code = {~q[DAC_W-1], q[DAC_W-2:0]};
        if (sat_hi) code = '1;
        if (sat_lo) code = '0;
    end

    assign div_end   = div_q == DW'(SCLK_DIV - 1);
    assign shift_end = (state_q == ST_SHIFT) && div_end && (half_q == 5'd31);
    assign gap_end   = gap_q == GW'(GAP_CYC - 1);
    assign busy      = state_q != ST_IDLE;

`ifdef DAC_PENDING_EN
    logic            pend_vld_q, pend_vld_d, store;
    logic [IN_W-1:0] pend_smp_d;

    // A pending sample enters LOAD during the last gap cycle so sync_n stays high exactly GAP_CYC.
    assign pend_take = pend_vld_q &&
                       (((state_q == ST_GAP) && (int'(gap_q) + 2 >= GAP_CYC)) ||
                        ((GAP_CYC == 1) && shift_end));
    assign gap_take  = (state_q == ST_GAP) && gap_end && sample_valid && !pend_vld_q;
    assign store     = sample_valid && busy && !gap_take;
    assign dropped   = store && pend_vld_q && !pend_take;

    always_comb begin
        pend_vld_d = pend_vld_q;
        pend_smp_d = pend_smp_q;
        if (pend_take) pend_vld_d = 1'b0;
        if (store) begin
            pend_vld_d = 1'b1;
            pend_smp_d = sample_in;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            pend_vld_q <= 1'b0;
            pend_smp_q <= '0;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_smp_q <= pend_smp_d;
        end
    end
`else
    assign pend_take  = 1'b0;
    assign gap_take   = 1'b0;
    assign pend_smp_q = '0;
    assign dropped    = sample_valid && busy;
`endif

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            half_q  <= '0;
            gap_q   <= '0;
            smp_q   <= '0;
            sreg_q  <= '0;
            sclk_q  <= 1'b1;
            sync_q  <= 1'b1;
            din_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            half_q  <= half_d;
            gap_q   <= gap_d;
            smp_q   <= smp_d;
            sreg_q  <= sreg_d;
            sclk_q  <= sclk_d;
            sync_q  <= sync_d;
            din_q   <= din_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        half_d  = half_q;
        gap_d   = gap_q;
        smp_d   = smp_q;
        sreg_d  = sreg_q;
        unique case (state_q)
            ST_IDLE: begin
                if (sample_valid) begin
                    state_d = ST_LOAD;
                    smp_d   = sample_in;
                end
            end
            ST_LOAD: begin
                state_d = ST_SHIFT;
                sreg_d  = 16'(code);
                div_d   = '0;
                half_d  = '0;
            end
            ST_SHIFT: begin
                div_d = div_end ? '0 : div_q + DW'(1);
                if (div_end) begin
                    half_d = half_q + 5'd1;
                    // next half is high: present the next bit on the rising edge
                    if (half_q[0]) sreg_d = {sreg_q[14:0], 1'b0};
                end
                if (shift_end) begin
                    gap_d   = '0;
                    state_d = pend_take ? ST_LOAD : ST_GAP;
                end
            end
            ST_GAP: begin
                gap_d = gap_q + GW'(1);
                if (pend_take || gap_take) state_d = ST_LOAD;
                else if (gap_end)          state_d = ST_IDLE;
            end
        endcase
        if (pend_take)     smp_d = pend_smp_q;
        else if (gap_take) smp_d = sample_in;
    end

    always_comb begin
        sat_pulse = (state_q == ST_LOAD) && (sat_hi || sat_lo);
        sync_d    = state_d != ST_SHIFT;
        sclk_d    = !((state_d == ST_SHIFT) && half_d[0]);
        din_d     = (state_d == ST_SHIFT) && sreg_d[15];
    end

    assign dac_sclk   = sclk_q;
    assign dac_sync_n = sync_q;
    assign dac_din    = din_q;
endmodule
